// File: rtl/uart_tx_frame_seq.sv
// Frame sequencer placed in front of a UART transmitter. It latches up to NUM_BYTES
// bytes and hands them out LSB-first, with one send strobe per byte, pacing on done_tx.
module uart_tx_frame_seq #(
   parameter  int NUM_BYTES  = 4,
   parameter  int BYTE_W     = 8,
   parameter  int GAP_CYCLES = 0,
   localparam int LEN_W      = $clog2(NUM_BYTES + 1)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [LEN_W-1:0]            len,
   input  logic [NUM_BYTES*BYTE_W-1:0] frame_in,
   input  logic                        abort,
   input  logic                        done_tx,
   output logic [BYTE_W-1:0]           data,
   output logic                        send,
   output logic                        busy,
   output logic                        frame_done
);
   localparam int FRAME_W = NUM_BYTES * BYTE_W;
   localparam int IDX_W   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_STROBE, S_WAIT_ACK, S_GAP
   } state_e;

   state_e             state_q, state_d;
   logic [FRAME_W-1:0] buf_q, buf_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [BYTE_W-1:0]  data_q, data_d;
   logic               send_q, send_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   function automatic logic [BYTE_W-1:0] byte_at(input logic [FRAME_W-1:0] f,
                                                 input logic [IDX_W-1:0]   k);
      return f[k*BYTE_W +: BYTE_W];
   endfunction

   // The length is stored as the index of the final byte, clamped to the buffer size.
   function automatic logic [IDX_W-1:0] last_index(input logic [LEN_W-1:0] l);
      if (int'(l) >= NUM_BYTES) return IDX_W'(NUM_BYTES - 1);
      return IDX_W'(int'(l) - 1);
   endfunction

   always_comb begin
      // NOTE: every _d gets a default before the case, so no path can infer a latch.
      state_d = state_q;
      buf_d   = buf_q;
      idx_d   = idx_q;
      last_d  = last_q;
      gap_d   = gap_q;
      data_d  = data_q;
      send_d  = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;
      if (abort && state_q != S_IDLE) begin
         state_d = S_IDLE;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (enable && len != '0) begin
                  buf_d   = frame_in;
                  last_d  = last_index(len);
                  idx_d   = '0;
                  busy_d  = 1'b1;
                  data_d  = frame_in[BYTE_W-1:0];
                  state_d = S_STROBE;
               end
            end
            S_STROBE: begin
               send_d  = 1'b1;
               state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
               if (done_tx) begin
                  if (idx_q == last_q) begin
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     idx_d = idx_q + 1'b1;
                     if (GAP_CYCLES == 0) begin
                        data_d  = byte_at(buf_q, idx_q + 1'b1);
                        state_d = S_STROBE;
                     end else begin
                        gap_d   = GAP_W'(GAP_CYCLES - 1);
                        state_d = S_GAP;
                     end
                  end
               end
            end
            S_GAP: begin
               if (gap_q == '0) begin
                  data_d  = byte_at(buf_q, idx_q);
                  state_d = S_STROBE;
               end else begin
                  gap_d = gap_q - 1'b1;
               end
            end
            default: begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               data_d  = '0;
            end
         endcase
      end
   end

   // NOTE: the frame buffer is reset along with the control state because it is a few flops, not a RAM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         buf_q   <= '0;
         idx_q   <= '0;
         last_q  <= '0;
         gap_q   <= '0;
         data_q  <= '0;
         send_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every register update from pre-edge values.
         state_q <= state_d;
         buf_q   <= buf_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         gap_q   <= gap_d;
         data_q  <= data_d;
         send_q  <= send_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign data       = data_q;
   assign send       = send_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame_seq.sv
// Self-checking bench for uart_tx_frame_seq. It drives a no-gap instance and a GAP_CYCLES=3 instance
// and checks each one against a byte-sequence and latency model built from the frame contents.
module tb_uart_tx_frame_seq;
   localparam int NB  = 4;
   localparam int BW  = 8;
   localparam int LW  = $clog2(NB + 1);
   localparam int FW  = NB * BW;
   localparam int GAP = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          enable = 1'b0;
   logic [LW-1:0] len = '0;
   logic [FW-1:0] frame_in = '0;
   logic          abort = 1'b0;
   logic          done_tx = 1'b0;
   logic          sel = 1'b0;

   logic [BW-1:0] data_a, data_b;
   logic          send_a, send_b, busy_a, busy_b, fd_a, fd_b;
   logic [BW-1:0] obs_data;
   logic          obs_send, obs_busy, obs_fd;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int fd_count = 0;
   int fd_cyc = 0;
   logic fd_busy = 1'b0;
   logic [BW-1:0] prev_data = '0;
   logic [BW-1:0] sent_q[$];
   logic [BW-1:0] pre_q[$];
   int            scyc_q[$];

   uart_tx_frame_seq #(.NUM_BYTES(NB), .BYTE_W(BW), .GAP_CYCLES(0)) dut_a (
      .clk(clk), .reset(reset), .enable(enable & ~sel), .len(len), .frame_in(frame_in),
      .abort(abort & ~sel), .done_tx(done_tx & ~sel),
      .data(data_a), .send(send_a), .busy(busy_a), .frame_done(fd_a));

   uart_tx_frame_seq #(.NUM_BYTES(NB), .BYTE_W(BW), .GAP_CYCLES(GAP)) dut_b (
      .clk(clk), .reset(reset), .enable(enable & sel), .len(len), .frame_in(frame_in),
      .abort(abort & sel), .done_tx(done_tx & sel),
      .data(data_b), .send(send_b), .busy(busy_b), .frame_done(fd_b));

   assign obs_data = sel ? data_b : data_a;
   assign obs_send = sel ? send_b : send_a;
   assign obs_busy = sel ? busy_b : busy_a;
   assign obs_fd   = sel ? fd_b   : fd_a;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Record what the selected transmitter would see, half a cycle away from the active edge.
   always @(negedge clk) begin
      if (obs_send) begin
         sent_q.push_back(obs_data);
         pre_q.push_back(prev_data);
         scyc_q.push_back(cyc);
      end
      if (obs_fd) begin
         fd_count <= fd_count + 1;
         fd_cyc   <= cyc;
         fd_busy  <= obs_busy;
      end
      prev_data <= obs_data;
   end

   task automatic wait_send(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         #1;
         if (sent_q.size() >= n) ok = 1'b1;
      end
   endtask

   task automatic clear_log();
      sent_q.delete();
      pre_q.delete();
      scyc_q.delete();
   endtask

   // The model: byte k of a frame is bits [8k +: 8]. The first send comes 2 cycles after the enable cycle.
   // Each later send comes GAP+2 cycles after the done_tx cycle. frame_done comes 1 cycle after the last done_tx.
   task automatic run_frame(input logic [FW-1:0] f, input int l, input int dly,
                            input bit strobe_ack, input bit busy_en, input string tag);
      int eff, gap, base_fd, en_cyc, ack_cyc, lat, exp_lat;
      logic [BW-1:0] exp_b;
      bit ok;
      eff = (l > NB) ? NB : l;
      gap = sel ? GAP : 0;
      clear_log();
      base_fd = fd_count;
      ack_cyc = 0;
      @(posedge clk); #1;
      frame_in = f; len = LW'(l); enable = 1'b1; en_cyc = cyc;
      @(posedge clk); #1;
      enable = 1'b0; frame_in = FW'($urandom); len = LW'($urandom);
      if (strobe_ack) begin
         done_tx = 1'b1;
         @(posedge clk); #1;
         done_tx = 1'b0;
      end
      for (int k = 0; k < eff; k++) begin
         wait_send(k + 1, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL %s send_arrival: byte %0d never sent, sends=%0d", tag, k, sent_q.size());
            return;
         end
         exp_b = f[k*BW +: BW];
         checks++;
         if (sent_q[k] !== exp_b) begin
            errors++;
            $display("FAIL %s data[%0d]: got %h expected %h", tag, k, sent_q[k], exp_b);
         end
         checks++;
         if (pre_q[k] !== exp_b) begin
            errors++;
            $display("FAIL %s data_setup[%0d]: got %h expected %h", tag, k, pre_q[k], exp_b);
         end
         lat     = (k == 0) ? scyc_q[k] - en_cyc : scyc_q[k] - ack_cyc;
         exp_lat = (k == 0) ? 2 : gap + 2;
         checks++;
         if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency[%0d]: got %0d expected %0d", tag, k, lat, exp_lat);
         end
         checks++;
         if (obs_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_during[%0d]: got %b expected 1", tag, k, obs_busy);
         end
         if (busy_en && k == 0) begin
            enable = 1'b1; frame_in = ~f; len = LW'(NB);
            @(posedge clk); #1;
            enable = 1'b0;
         end
         repeat (dly) @(posedge clk);
         #1;
         done_tx = 1'b1; ack_cyc = cyc;
         @(posedge clk); #1;
         done_tx = 1'b0;
      end
      repeat (8) @(negedge clk);
      #1;
      checks++;
      if (fd_count !== base_fd + 1) begin
         errors++;
         $display("FAIL %s frame_done_count: got %0d expected %0d", tag, fd_count - base_fd, 1);
      end
      checks++;
      if (fd_cyc !== ack_cyc + 1) begin
         errors++;
         $display("FAIL %s frame_done_latency: got %0d expected %0d", tag, fd_cyc - ack_cyc, 1);
      end
      checks++;
      if (fd_busy !== 1'b0 || obs_busy !== 1'b0) begin
         errors++;
         $display("FAIL %s busy_end: at_done=%b now=%b expected 0/0", tag, fd_busy, obs_busy);
      end
      checks++;
      if (sent_q.size() !== eff) begin
         errors++;
         $display("FAIL %s send_count: got %0d expected %0d", tag, sent_q.size(), eff);
      end
   endtask

   task automatic test_reset();
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({data_a, send_a, busy_a, fd_a} !== '0 || {data_b, send_b, busy_b, fd_b} !== '0) begin
         errors++;
         $display("FAIL reset_state: a=%h/%b/%b/%b b=%h/%b/%b/%b expected all 0",
                  data_a, send_a, busy_a, fd_a, data_b, send_b, busy_b, fd_b);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_len2();
      sel = 1'b0;
      run_frame(32'hDDCCBBAA, 2, 5, 1'b0, 1'b0, "len2");
   endtask

   task automatic test_len4_strobe_ack();
      sel = 1'b0;
      run_frame(32'hDDCCBBAA, 4, 5, 1'b1, 1'b0, "len4_strobe_ack");
   endtask

   task automatic test_gap();
      sel = 1'b1;
      run_frame(32'hDDCCBBAA, 2, 5, 1'b0, 1'b0, "gap3");
      sel = 1'b0;
   endtask

   task automatic test_len_zero_and_clamp();
      int base_fd;
      bit busy_seen;
      sel = 1'b0;
      clear_log();
      base_fd = fd_count;
      busy_seen = 1'b0;
      @(posedge clk); #1;
      frame_in = FW'($urandom); len = '0; enable = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      enable = 1'b0; abort = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (obs_busy !== 1'b0) busy_seen = 1'b1;
      end
      checks++;
      if (sent_q.size() !== 0 || busy_seen || fd_count !== base_fd) begin
         errors++;
         $display("FAIL len_zero: sends=%0d busy_seen=%b frame_dones=%0d expected 0/0/0",
                  sent_q.size(), busy_seen, fd_count - base_fd);
      end
      run_frame(FW'($urandom), 7, 2, 1'b0, 1'b0, "clamp_len7");
   endtask

   task automatic test_abort();
      logic [FW-1:0] f;
      int base_fd;
      bit ok;
      sel = 1'b0;
      f = 32'hDDCCBBAA;
      clear_log();
      base_fd = fd_count;
      @(posedge clk); #1;
      frame_in = f; len = LW'(4); enable = 1'b1;
      @(posedge clk); #1;
      enable = 1'b0;
      wait_send(1, ok);
      repeat (2) @(posedge clk);
      #1 done_tx = 1'b1;
      @(posedge clk); #1;
      done_tx = 1'b0;
      wait_send(2, ok);
      checks++;
      if (!ok || sent_q[1] !== 8'hBB) begin
         errors++;
         $display("FAIL abort_setup: sends=%0d expected byte1=bb", sent_q.size());
         return;
      end
      repeat (2) @(posedge clk);
      #1 abort = 1'b1; done_tx = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0; done_tx = 1'b0;
      checks++;
      if (obs_busy !== 1'b0 || obs_send !== 1'b0 || obs_fd !== 1'b0 || obs_data !== 8'hBB) begin
         errors++;
         $display("FAIL abort_next_cycle: busy=%b send=%b fd=%b data=%h expected 0/0/0/bb",
                  obs_busy, obs_send, obs_fd, obs_data);
      end
      repeat (15) @(negedge clk);
      #1;
      checks++;
      if (sent_q.size() !== 2 || fd_count !== base_fd) begin
         errors++;
         $display("FAIL abort_quiet: sends=%0d frame_dones=%0d expected 2/0",
                  sent_q.size(), fd_count - base_fd);
      end
      run_frame(FW'($urandom), 3, 1, 1'b0, 1'b0, "after_abort");
   endtask

   task automatic test_reset_mid_gap();
      logic [FW-1:0] f;
      int base_fd;
      bit ok;
      sel = 1'b1;
      f = FW'($urandom) | FW'(1);
      clear_log();
      base_fd = fd_count;
      @(posedge clk); #1;
      frame_in = f; len = LW'(2); enable = 1'b1;
      @(posedge clk); #1;
      enable = 1'b0;
      wait_send(1, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL reset_gap_setup: no first send, sends=%0d", sent_q.size());
      end
      repeat (2) @(posedge clk);
      #1 done_tx = 1'b1;
      @(posedge clk); #1;
      done_tx = 1'b0;
      #2 reset = 1'b1;
      #1;
      checks++;
      if (obs_data !== '0 || obs_send !== 1'b0 || obs_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_gap: data=%h send=%b busy=%b expected 00/0/0",
                  obs_data, obs_send, obs_busy);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      checks++;
      if (sent_q.size() !== 1 || fd_count !== base_fd) begin
         errors++;
         $display("FAIL reset_no_resume: sends=%0d frame_dones=%0d expected 1/0",
                  sent_q.size(), fd_count - base_fd);
      end
      run_frame(FW'($urandom), 4, 2, 1'b0, 1'b1, "post_reset_busy_en");
      sel = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 10; i++) begin
         sel = 1'($urandom_range(0, 1));
         run_frame(FW'($urandom), int'($urandom_range(1, 7)), int'($urandom_range(1, 6)),
                   1'($urandom_range(0, 1)), 1'b0, $sformatf("rand%0d", i));
      end
      sel = 1'b0;
   endtask

   task automatic test_back_to_back();
      sel = 1'b0;
      run_frame(FW'($urandom), 1, 1, 1'b0, 1'b0, "b2b_first");
      run_frame(FW'($urandom), 2, 1, 1'b0, 1'b0, "b2b_second");
   endtask

   initial begin
      test_reset();
      test_len2();
      test_len4_strobe_ack();
      test_gap();
      test_len_zero_and_clamp();
      test_abort();
      test_reset_mid_gap();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached after %0d cycles", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
